// File: rtl/cache_refill_if.sv
// rtl/cache_refill_if.sv - memory-side bus of the cache refill controller
// Groups the write-back channel (wr_*), the line-read request channel (rd_*)
// and the read-return beat stream (ret_*).
//   master: refill controller (drives wr_req/wr_addr/wr_data, rd_req/rd_addr)
//   slave : memory (drives wr_rdy, rd_rdy, ret_valid/ret_last/ret_data)
interface cache_refill_if #(
  parameter int BEATS = 16
);
  logic                  wr_req;
  logic [31:0]           wr_addr;
  logic [BEATS*32-1:0]   wr_data;
  logic                  wr_rdy;
  logic                  rd_req;
  logic [31:0]           rd_addr;
  logic                  rd_rdy;
  logic                  ret_valid;
  logic                  ret_last;
  logic [31:0]           ret_data;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr,
    input  wr_rdy, rd_rdy, ret_valid, ret_last, ret_data
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
    output wr_rdy, rd_rdy, ret_valid, ret_last, ret_data
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - miss-handling FSM for the 4-way 64-set 64B-line cache
// On a miss: latch request and victim, write back the victim if dirty, burst-read
// the new line, write it into the chosen way, then pulse the LRU update.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   miss_req/miss_addr   miss pulse and address from lookup (sampled in IDLE only)
//   way_sel              one-hot victim way from the LRU selector
//   victim_dirty/_tag/_line  victim state, sampled with miss_req
//   busy                 high while a miss is in progress
//   fill_we/_way/_index/_tag/_data  one-cycle array write of the new line
//   lru_visit/lru_en     one-cycle LRU update
//   miss_done            one-cycle completion pulse
//   mem                  memory bus (write-back, read request, read return)
module cache_refill_ctrl #(
  parameter int BEATS = 16,
  parameter int TAG_W = 20
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                miss_req,
  input  logic [31:0]         miss_addr,
  input  logic [3:0]          way_sel,
  input  logic                victim_dirty,
  input  logic [TAG_W-1:0]    victim_tag,
  input  logic [BEATS*32-1:0] victim_line,
  output logic                busy,
  output logic                fill_we,
  output logic [3:0]          fill_way,
  output logic [5:0]          fill_index,
  output logic [TAG_W-1:0]    fill_tag,
  output logic [BEATS*32-1:0] fill_data,
  output logic [3:0]          lru_visit,
  output logic                lru_en,
  output logic                miss_done,
  cache_refill_if.master      mem
);

  localparam int CNT_W = $clog2(BEATS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WB   = 3'd1,
    S_RD   = 3'd2,
    S_RECV = 3'd3,
    S_FILL = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [31:6]         addr_q;
  logic [3:0]          way_q;
  logic [TAG_W-1:0]    vtag_q;
  logic [BEATS*32-1:0] vline_q;
  logic [BEATS*32-1:0] line_q;
  logic [CNT_W-1:0]    cnt_q;

  logic way_ok;
  logic accept;
  logic last_beat;
  logic unused_addr_lsb;

  // Byte offset inside the line never matters to a whole-line refill.
  assign unused_addr_lsb = ^miss_addr[5:0];

  assign way_ok    = (way_sel != 4'b0000) && ((way_sel & (way_sel - 4'd1)) == 4'b0000);
  assign accept    = (state == S_IDLE) && miss_req;
  assign last_beat = mem.ret_valid && (mem.ret_last || (cnt_q == CNT_W'(BEATS - 1)));

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (miss_req) state_nxt = victim_dirty ? S_WB : S_RD;
      S_WB:   if (mem.wr_rdy) state_nxt = S_RD;
      S_RD:   if (mem.rd_rdy) state_nxt = S_RECV;
      S_RECV: if (last_beat) state_nxt = S_FILL;
      S_FILL: state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy        = (state != S_IDLE);
    mem.wr_req  = (state == S_WB);
    mem.rd_req  = (state == S_RD);
    fill_we     = (state == S_FILL);
    lru_en      = (state == S_DONE);
    miss_done   = (state == S_DONE);
    lru_visit   = (state == S_DONE) ? way_q : 4'b0000;
  end

  // Request/victim latches and line assembly. The line buffer is cleared on
  // acceptance so that an early ret_last leaves the missing beats at zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q  <= '0;
      way_q   <= '0;
      vtag_q  <= '0;
      vline_q <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      addr_q  <= miss_addr[31:6];
      way_q   <= way_ok ? way_sel : 4'b0001;
      vtag_q  <= victim_tag;
      vline_q <= victim_line;
      line_q  <= '0;
      cnt_q   <= '0;
    end else if ((state == S_RECV) && mem.ret_valid) begin
      line_q[{cnt_q, 5'b00000} +: 32] <= mem.ret_data;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign mem.wr_addr = {vtag_q, addr_q[11:6], 6'b000000};
  assign mem.wr_data = vline_q;
  assign mem.rd_addr = {addr_q, 6'b000000};
  assign fill_way    = way_q;
  assign fill_index  = addr_q[11:6];
  assign fill_tag    = addr_q[31:32-TAG_W];
  assign fill_data   = line_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - self-checking bench for cache_refill_ctrl
module tb_cache_refill_ctrl;

  logic         clk;
  logic         rstn;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic [3:0]   way_sel;
  logic         victim_dirty;
  logic [19:0]  victim_tag;
  logic [511:0] victim_line;
  logic         busy;
  logic         fill_we;
  logic [3:0]   fill_way;
  logic [5:0]   fill_index;
  logic [19:0]  fill_tag;
  logic [511:0] fill_data;
  logic [3:0]   lru_visit;
  logic         lru_en;
  logic         miss_done;

  cache_refill_if #(.BEATS(16)) mem ();

  cache_refill_ctrl #(.BEATS(16), .TAG_W(20)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .miss_req     (miss_req),
    .miss_addr    (miss_addr),
    .way_sel      (way_sel),
    .victim_dirty (victim_dirty),
    .victim_tag   (victim_tag),
    .victim_line  (victim_line),
    .busy         (busy),
    .fill_we      (fill_we),
    .fill_way     (fill_way),
    .fill_index   (fill_index),
    .fill_tag     (fill_tag),
    .fill_data    (fill_data),
    .lru_visit    (lru_visit),
    .lru_en       (lru_en),
    .miss_done    (miss_done),
    .mem          (mem.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  way;
    logic        dirty;
    logic [19:0] vtag;
    int          stall;
    int          nbeats;
    logic [31:0] base;
    bit          poke;
    logic [3:0]  exp_way;
    logic [5:0]  exp_idx;
    logic [19:0] exp_tag;
    logic [31:0] exp_rd;
    logic [31:0] exp_wr;
  } vec_t;

  vec_t tbl [5];

  function automatic logic [511:0] mk_vline(input int id);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = 32'hF000_0000 + 32'(id * 256 + k);
    return l;
  endfunction

  // Runs one miss starting at the current negedge and returns at the negedge
  // after miss_done, where the controller must be idle again.
  task automatic run_miss(input vec_t v, input int id);
    logic [511:0] vline;
    logic [511:0] exp_line;
    logic [3:0]   c_way;
    logic [5:0]   c_idx;
    logic [19:0]  c_tag;
    logic [511:0] c_data;
    logic [3:0]   c_visit;
    int cyc, wr_n, wr_bad, rd_n, rd_bad, first_rd, overlap;
    int fill_n, fill_cyc, lru_n, lru_cyc, done_cyc, k;
    bit recv, done;
    string p;
    p = $sformatf("v%0d_", id);
    vline = mk_vline(id);
    for (int j = 0; j < 16; j++) exp_line[32*j +: 32] = (j < v.nbeats) ? v.base + 32'(j) : 32'h0;
    cyc = 0; wr_n = 0; wr_bad = 0; rd_n = 0; rd_bad = 0; first_rd = -1; overlap = 0;
    fill_n = 0; fill_cyc = -1; lru_n = 0; lru_cyc = -2; done_cyc = -3; k = 0;
    recv = 0; done = 0;
    c_way = '0; c_idx = '0; c_tag = '0; c_data = '0; c_visit = '0;
    miss_req = 1'b1; miss_addr = v.addr; way_sel = v.way; victim_dirty = v.dirty;
    victim_tag = v.vtag; victim_line = vline;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      miss_req     = v.poke && (cyc >= 2) && (cyc <= 4);
      miss_addr    = ~v.addr;
      way_sel      = ~v.way;
      victim_dirty = 1'b1;
      victim_tag   = ~v.vtag;
      victim_line  = ~vline;
      if (mem.wr_req) begin
        wr_n++;
        if (mem.wr_addr !== v.exp_wr || mem.wr_data !== vline) wr_bad++;
        if (mem.rd_req) overlap++;
      end
      if (mem.rd_req) begin
        rd_n++;
        if (first_rd < 0) first_rd = cyc;
        if (mem.rd_addr !== v.exp_rd) rd_bad++;
      end
      if (fill_we) begin
        fill_n++; fill_cyc = cyc;
        c_way = fill_way; c_idx = fill_index; c_tag = fill_tag; c_data = fill_data;
      end
      if (lru_en) begin
        lru_n++; lru_cyc = cyc; c_visit = lru_visit;
      end
      if (miss_done) begin
        done = 1; done_cyc = cyc;
      end
      mem.wr_rdy = mem.wr_req && (wr_n > v.stall);
      mem.rd_rdy = mem.rd_req;
      if (recv && k < v.nbeats + 2) begin
        mem.ret_valid = 1'b1;
        mem.ret_data  = v.base + 32'(k);
        mem.ret_last  = (k == v.nbeats - 1);
        k++;
      end else begin
        mem.ret_valid = 1'b0; mem.ret_data = '0; mem.ret_last = 1'b0;
      end
      if (mem.rd_req && mem.rd_rdy) recv = 1;
    end
    check({p, "completed"}, 512'(done), 512'(1));
    check({p, "wr_cycles"}, 512'(wr_n), 512'(v.dirty ? v.stall + 1 : 0));
    check({p, "wr_addr_data_stable"}, 512'(wr_bad), 512'(0));
    check({p, "rd_addr"}, 512'(rd_bad), 512'(0));
    check({p, "rd_cycles"}, 512'(rd_n), 512'(1));
    check({p, "first_rd_cycle"}, 512'(first_rd), 512'(v.dirty ? v.stall + 2 : 1));
    check({p, "wr_rd_overlap"}, 512'(overlap), 512'(0));
    check({p, "fill_we_count"}, 512'(fill_n), 512'(1));
    check({p, "fill_way"}, 512'(c_way), 512'(v.exp_way));
    check({p, "fill_index"}, 512'(c_idx), 512'(v.exp_idx));
    check({p, "fill_tag"}, 512'(c_tag), 512'(v.exp_tag));
    check({p, "fill_data"}, c_data, exp_line);
    check({p, "lru_count"}, 512'(lru_n), 512'(1));
    check({p, "lru_after_fill"}, 512'(lru_cyc), 512'(fill_cyc + 1));
    check({p, "done_with_lru"}, 512'(done_cyc), 512'(lru_cyc));
    check({p, "lru_visit"}, 512'(c_visit), 512'(v.exp_way));
    @(negedge clk);
    mem.ret_valid = 1'b0; mem.ret_data = '0; mem.ret_last = 1'b0;
    mem.wr_rdy = 1'b0; mem.rd_rdy = 1'b0;
    check({p, "idle_after_done"}, 512'({busy, lru_en, miss_done, fill_we}), 512'(0));
  endtask

  int bad_cnt;

  initial begin
    //        addr          way    d  vtag      st nb base          poke exp_way idx    tag       rd            wr
    tbl[0] = '{32'h1234_5680, 4'b0100, 1'b0, 20'h00000, 0, 16, 32'h0000_0100, 1'b0, 4'b0100, 6'h1A, 20'h12345, 32'h1234_5680, 32'h0};
    tbl[1] = '{32'h0F0F_0140, 4'b0010, 1'b1, 20'hABCDE, 3, 16, 32'hA000_0000, 1'b0, 4'b0010, 6'h05, 20'h0F0F0, 32'h0F0F_0140, 32'hABCD_E140};
    tbl[2] = '{32'hDEAD_BEEF, 4'b1000, 1'b0, 20'h00000, 0,  4, 32'h5500_0000, 1'b1, 4'b1000, 6'h3B, 20'hDEADB, 32'hDEAD_BEC0, 32'h0};
    tbl[3] = '{32'h0000_0FC0, 4'b0110, 1'b1, 20'h00001, 0, 16, 32'h0BAD_0000, 1'b0, 4'b0001, 6'h3F, 20'h00000, 32'h0000_0FC0, 32'h0000_1FC0};
    tbl[4] = '{32'h8000_0000, 4'b0000, 1'b0, 20'h00000, 0,  1, 32'h0000_0077, 1'b0, 4'b0001, 6'h00, 20'h80000, 32'h8000_0000, 32'h0};

    rstn = 1'b0; miss_req = 1'b0; miss_addr = '0; way_sel = '0; victim_dirty = 1'b0;
    victim_tag = '0; victim_line = '0;
    mem.wr_rdy = 1'b0; mem.rd_rdy = 1'b0; mem.ret_valid = 1'b0; mem.ret_last = 1'b0; mem.ret_data = '0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", 512'({busy, mem.wr_req, mem.rd_req, fill_we, lru_en, miss_done}), 512'(0));
    check("reset_buses", 512'({fill_way, fill_index, fill_tag, lru_visit, mem.wr_addr, mem.rd_addr}), 512'(0));
    check("reset_fill_data", fill_data, 512'(0));
    rstn = 1'b1;
    @(negedge clk);

    // Back-to-back: each new miss is issued the cycle after the previous miss_done.
    for (int i = 0; i < 5; i++) run_miss(tbl[i], i);

    // Reset during RECV after 7 beats.
    miss_req = 1'b1; miss_addr = 32'h2468_ACC0; way_sel = 4'b0010; victim_dirty = 1'b0;
    victim_tag = 20'h11111; victim_line = '1;
    @(negedge clk);
    miss_req = 1'b0;
    check("rst_seq_rd_req", 512'(mem.rd_req), 512'(1));
    mem.rd_rdy = 1'b1;
    @(negedge clk);
    mem.rd_rdy = 1'b0;
    for (int k = 0; k < 7; k++) begin
      mem.ret_valid = 1'b1; mem.ret_data = 32'hC0C0_0000 + 32'(k); mem.ret_last = 1'b0;
      @(negedge clk);
    end
    check("rst_seq_busy_before", 512'(busy), 512'(1));
    rstn = 1'b0;
    #1;
    check("rst_seq_ctrl_zero", 512'({busy, mem.wr_req, mem.rd_req, fill_we, lru_en, miss_done}), 512'(0));
    check("rst_seq_bus_zero", 512'({fill_way, fill_index, fill_tag, lru_visit, mem.wr_addr, mem.rd_addr}), 512'(0));
    check("rst_seq_data_zero", fill_data | mem.wr_data, 512'(0));
    bad_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 2) rstn = 1'b1;
      mem.ret_valid = 1'b1; mem.ret_data = 32'hEEEE_0000 + 32'(k); mem.ret_last = (k == 5);
      if (fill_we || lru_en || busy || miss_done) bad_cnt++;
    end
    @(negedge clk);
    if (fill_we || lru_en || busy || miss_done) bad_cnt++;
    mem.ret_valid = 1'b0; mem.ret_data = '0; mem.ret_last = 1'b0;
    check("rst_seq_no_activity", 512'(bad_cnt), 512'(0));
    run_miss(tbl[0], 5);
    run_miss(tbl[1], 6);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
